lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_xfer.sv | 92 +++++++++
 rtl/lcd_ctrl.sv | 159 +++++++++++++++
 tb/tb_lcd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 refresh controller: command bytes,
// sequencer and transfer state encodings, and small helper functions.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_L1_ADDR,
      ST_L1_CHARS,
      ST_L2_ADDR,
      ST_L2_CHARS,
      ST_IDLE
   } lcd_state_t;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_SETUP,
      XF_STROBE,
      XF_WAIT
   } xfer_phase_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] step);
      case (step)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte HD44780 write: setup cycle, EN strobe, then a settle wait.
// xfer_done marks the last wait cycle so a new go can start the next setup with no gap.
module lcd_xfer
   import lcd_pkg::*;
#(
   parameter int T_EN  = 25,
   parameter int T_CMD = 2000,
   parameter int T_CLR = 82000,
   parameter int TW    = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       rs,
   input  logic [7:0] din,
   input  logic       long_wait,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic       xfer_done
);

   xfer_phase_t   phase_reg, phase_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [7:0]    data_reg;
   logic          rs_reg;
   logic          long_reg;
   logic          load;
   logic [TW-1:0] wait_last;

   assign wait_last = long_reg ? TW'(T_CLR - 1) : TW'(T_CMD - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg <= XF_IDLE;
         timer_reg <= '0;
         data_reg  <= '0;
         rs_reg    <= 1'b0;
         long_reg  <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         timer_reg <= timer_next;
         if (load) begin
            data_reg <= din;
            rs_reg   <= rs;
            long_reg <= long_wait;
         end
      end
   end

   always_comb begin
      phase_next = phase_reg;
      timer_next = timer_reg;
      xfer_done  = 1'b0;
      load       = 1'b0;
      case (phase_reg)
         XF_IDLE:   load = go;
         XF_SETUP: begin
            phase_next = XF_STROBE;
            timer_next = '0;
         end
         XF_STROBE: begin
            if (timer_reg == TW'(T_EN - 1)) begin
               phase_next = XF_WAIT;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         XF_WAIT: begin
            if (timer_reg == wait_last) begin
               xfer_done  = 1'b1;
               load       = go;
               phase_next = XF_IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: phase_next = XF_IDLE;
      endcase
      if (load) begin
         phase_next = XF_SETUP;
         timer_next = '0;
      end
   end

   assign lcd_data = data_reg;
   assign lcd_rs   = rs_reg;
   // EN decodes straight from the phase register, so async reset drops it at once.
   assign lcd_en   = (phase_reg == XF_STROBE);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 refresh sequencer: power-up wait, init commands, then both lines
// from the character ROM; later refreshes on start skip power-up and init.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_EN    = 25,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [4:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       busy,
   output logic       done
);

   localparam int TW = $clog2(max3(T_PWRUP, T_CLR, (T_CMD > T_EN) ? T_CMD : T_EN) + 1);

   lcd_state_t    state_reg, state_next;
   logic [1:0]    step_reg, step_next;
   logic [4:0]    idx_reg, idx_next;
   logic [TW-1:0] pw_reg, pw_next;
   logic          done_reg;
   logic          launch;
   logic          xfer_rs;
   logic [7:0]    xfer_byte;
   logic          xfer_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_PWRUP;
         step_reg  <= '0;
         idx_reg   <= '0;
         pw_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         idx_reg   <= idx_next;
         pw_reg    <= pw_next;
         done_reg  <= (state_next == ST_IDLE) && (state_reg != ST_IDLE);
      end
   end

   // Next transfer is chosen from the post-transition state so it can launch
   // in the same cycle the previous one finishes.
   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      idx_next   = idx_reg;
      pw_next    = pw_reg;
      launch     = 1'b0;
      case (state_reg)
         ST_PWRUP: begin
            if (pw_reg == TW'(T_PWRUP - 1)) begin
               state_next = ST_INIT;
               step_next  = '0;
               launch     = 1'b1;
            end else begin
               pw_next = pw_reg + 1'b1;
            end
         end
         ST_INIT: begin
            if (xfer_done) begin
               launch = 1'b1;
               if (step_reg == 2'd3) begin
                  state_next = ST_L1_ADDR;
                  step_next  = '0;
               end else begin
                  step_next = step_reg + 2'd1;
               end
            end
         end
         ST_L1_ADDR: begin
            if (xfer_done) begin
               state_next = ST_L1_CHARS;
               launch     = 1'b1;
            end
         end
         ST_L1_CHARS: begin
            if (xfer_done) begin
               idx_next = idx_reg + 5'd1;
               launch   = 1'b1;
               if (idx_reg == 5'd15)
                  state_next = ST_L2_ADDR;
            end
         end
         ST_L2_ADDR: begin
            if (xfer_done) begin
               state_next = ST_L2_CHARS;
               launch     = 1'b1;
            end
         end
         ST_L2_CHARS: begin
            if (xfer_done) begin
               idx_next = idx_reg + 5'd1;  // 31 -> 0 on the way into IDLE
               if (idx_reg == 5'd31)
                  state_next = ST_IDLE;
               else
                  launch = 1'b1;
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_next = ST_L1_ADDR;
               launch     = 1'b1;
            end
         end
         default: state_next = ST_PWRUP;
      endcase
   end

   always_comb begin
      xfer_rs   = 1'b0;
      xfer_byte = 8'h00;
      case (state_next)
         ST_INIT:     xfer_byte = init_cmd(step_next);
         ST_L1_ADDR:  xfer_byte = CMD_LINE1;
         ST_L2_ADDR:  xfer_byte = CMD_LINE2;
         ST_L1_CHARS,
         ST_L2_CHARS: begin
            xfer_rs   = 1'b1;
            xfer_byte = rom_data;
         end
         default: ;
      endcase
   end

   assign rom_addr = idx_next;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_reg;
   assign LCD_RW   = 1'b0;

   lcd_xfer #(
      .T_EN  (T_EN),
      .T_CMD (T_CMD),
      .T_CLR (T_CLR),
      .TW    (TW)
   ) u_xfer (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (launch),
      .rs        (xfer_rs),
      .din       (xfer_byte),
      .long_wait (xfer_byte == CMD_CLEAR),
      .lcd_data  (LCD_DATA),
      .lcd_rs    (LCD_RS),
      .lcd_en    (LCD_EN),
      .xfer_done (xfer_done)
   );

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: EN-fall capture log compared against a byte-list model
// built from the ROM contents, with strobe/gap timing and done/busy checks.
module tb_lcd_ctrl;

   localparam int T_PWRUP = 10;
   localparam int T_EN    = 2;
   localparam int T_CMD   = 4;
   localparam int T_CLR   = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] LCD_DATA;
   logic       LCD_RS, LCD_RW, LCD_EN, busy, done;
   logic [7:0] rom [32];

   assign rom_data = rom[rom_addr];
   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_PWRUP (T_PWRUP),
      .T_EN    (T_EN),
      .T_CMD   (T_CMD),
      .T_CLR   (T_CLR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .LCD_DATA (LCD_DATA),
      .LCD_RS   (LCD_RS),
      .LCD_RW   (LCD_RW),
      .LCD_EN   (LCD_EN),
      .busy     (busy),
      .done     (done)
   );

   // ---------------- bus monitor (records only, never judges) ----------------
   typedef struct {
      logic [8:0] val;        // {rs, data} captured on EN fall
      int         hi_len;
      int         gap;        // EN-low samples before this rise
      bit         gap_valid;
      bit         bus_ok;     // RS/DATA steady setup..fall, RW low
   } xrec_t;

   xrec_t      xlog[$];
   int         done_cnt = 0;
   int         done_bad = 0;
   bit         prev_en, prev_done, gv_m, pend_gv, pend_ok;
   logic [8:0] prev_val, hi_val;
   int         hi_cnt, lo_cnt, pend_gap;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en   = 1'b0;
         prev_done = 1'b0;
         gv_m      = 1'b0;
         hi_cnt    = 0;
         lo_cnt    = 0;
      end else begin
         if (LCD_EN && !prev_en) begin
            pend_gap = lo_cnt;
            pend_gv  = gv_m;
            pend_ok  = ({LCD_RS, LCD_DATA} == prev_val);
            hi_val   = {LCD_RS, LCD_DATA};
            hi_cnt   = 1;
         end else if (LCD_EN) begin
            hi_cnt++;
            if ({LCD_RS, LCD_DATA} != hi_val) pend_ok = 1'b0;
         end else if (prev_en) begin
            xrec_t r;
            r.val       = hi_val;
            r.hi_len    = hi_cnt;
            r.gap       = pend_gap;
            r.gap_valid = pend_gv;
            r.bus_ok    = pend_ok && ({LCD_RS, LCD_DATA} == hi_val) && !LCD_RW;
            xlog.push_back(r);
            lo_cnt = 1;
            gv_m   = 1'b1;
         end else begin
            lo_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (busy || prev_done) done_bad++;
            gv_m = 1'b0;
         end
         prev_en   = LCD_EN;
         prev_done = done;
         prev_val  = {LCD_RS, LCD_DATA};
      end
   end

   // ---------------- checking helpers ----------------
   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected capture list straight from the display rules and the ROM image.
   task automatic build_exp(input bit with_init);
      exp_q.delete();
      if (with_init) begin
         exp_q.push_back(9'h038);
         exp_q.push_back(9'h00C);
         exp_q.push_back(9'h001);
         exp_q.push_back(9'h006);
      end
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, rom[i]});
      exp_q.push_back(9'h0C0);
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, rom[i]});
   endtask

   task automatic compare_seq(input string tag, input int base);
      int n;
      n = xlog.size() - base;
      check($sformatf("%s length", tag), n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         check($sformatf("%s[%0d] rs_data", tag, i), xlog[base+i].val, exp_q[i]);
         check($sformatf("%s[%0d] en_high", tag, i), xlog[base+i].hi_len, T_EN);
         check($sformatf("%s[%0d] bus_stable", tag, i), xlog[base+i].bus_ok, 1);
         if (i > 0)
            check($sformatf("%s[%0d] en_low_gap", tag, i), xlog[base+i].gap,
                  (exp_q[i-1][7:0] == 8'h01) ? T_CLR + 1 : T_CMD + 1);
      end
   endtask

   task automatic wait_log(input string tag, input int target);
      int n = 0;
      while (xlog.size() < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " log reached"}, xlog.size() >= target, 1);
   endtask

   task automatic wait_en(input string tag);
      int n = 0;
      while (!LCD_EN && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " en seen"}, LCD_EN, 1);
   endtask

   task automatic wait_done(input string tag, input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done seen"}, done_cnt > d0, 1);
   endtask

   task automatic reset_state(input string tag);
      check({tag, " LCD_EN"}, LCD_EN, 0);
      check({tag, " LCD_RS"}, LCD_RS, 0);
      check({tag, " LCD_RW"}, LCD_RW, 0);
      check({tag, " LCD_DATA"}, LCD_DATA, 8'h00);
      check({tag, " rom_addr"}, rom_addr, 5'd0);
      check({tag, " busy"}, busy, 1);
      check({tag, " done"}, done, 0);
   endtask

   // Called right after release: PWRUP quiet period, then setup, then EN.
   task automatic powerup_check(input string tag);
      int n = 0;
      int bad = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (LCD_EN) break;
         if (n < T_PWRUP && (LCD_DATA != 8'h00 || LCD_RS || LCD_RW || !busy)) bad++;
      end
      check({tag, " first EN edge"}, n, T_PWRUP + 1);
      check({tag, " quiet outputs"}, bad, 0);
   endtask

   // ---------------- scenario table ----------------
   typedef struct {
      string name;
      int    start_at;   // char index for an extra start pulse mid-refresh, -1 none
      bit    rand_rom;
      int    exp_len;
      int    exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int b, d0, db, target;

      vecs[0] = '{"refresh", -1, 1'b0, 34, 1};
      vecs[1] = '{"start_char10", 9, 1'b0, 34, 1};
      vecs[2] = '{"rand_refresh", -1, 1'b1, 34, 1};
      vecs[3] = '{"rand_start_l2", 20, 1'b1, 34, 1};
      vecs[4] = '{"rand_start_l1", 2, 1'b1, 34, 1};

      for (int i = 0; i < 32; i++) rom[i] = 8'h20;
      rom[6]  = "J";
      rom[7]  = "A";
      rom[8]  = "y";
      rom[23] = "A";

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_state("reset");

      // Power-up: automatic full sequence with no start.
      b  = xlog.size();
      d0 = done_cnt;
      db = done_bad;
      rst_n = 1'b1;
      powerup_check("pwrup");
      wait_done("pwrup", d0);
      repeat (40) @(negedge clk);
      build_exp(1'b1);
      compare_seq("pwrup", b);
      check("pwrup done count", done_cnt - d0, 1);
      check("pwrup done shape", done_bad - db, 0);
      check("pwrup idle busy", busy, 0);

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].rand_rom)
            for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(32, 126));
         repeat ($urandom_range(1, 15)) @(negedge clk);
         check({vecs[v].name, " idle before"}, busy, 0);
         b  = xlog.size();
         d0 = done_cnt;
         db = done_bad;
         start = 1'b1;
         @(posedge clk);
         #1;
         check({vecs[v].name, " busy after start"}, busy, 1);
         @(negedge clk);
         start = 1'b0;
         if (vecs[v].start_at >= 0) begin
            target = b + ((vecs[v].start_at < 16) ? 1 + vecs[v].start_at : 2 + vecs[v].start_at);
            wait_log(vecs[v].name, target);
            wait_en(vecs[v].name);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_done(vecs[v].name, d0);
         repeat (60) @(negedge clk);
         check({vecs[v].name, " transfers"}, xlog.size() - b, vecs[v].exp_len);
         check({vecs[v].name, " done count"}, done_cnt - d0, vecs[v].exp_done);
         check({vecs[v].name, " done shape"}, done_bad - db, 0);
         check({vecs[v].name, " idle after"}, busy, 0);
         build_exp(1'b0);
         compare_seq(vecs[v].name, b);
         $display("vector %s: %0d transfers logged", vecs[v].name, xlog.size() - b);
      end

      // Reset during EN high of the fifth character, then full restart.
      b = xlog.size();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_log("midrst", b + 5);
      wait_en("midrst");
      #2;
      rst_n = 1'b0;
      #1;
      reset_state("midrst");
      repeat (3) @(negedge clk);
      b  = xlog.size();
      d0 = done_cnt;
      rst_n = 1'b1;
      powerup_check("midrst");
      wait_done("midrst", d0);
      repeat (20) @(negedge clk);
      build_exp(1'b1);
      compare_seq("midrst", b);
      check("midrst done count", done_cnt - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
